// File: rtl/rv_instr_loader_if.sv
// Byte-stream in / instruction-RAM write port out for the boot loader.
// The slave modport is the loader side; the master modport drives the stream and watches the write port.
interface rv_instr_loader_if #(
  parameter int AW = 10
);
  logic          start_i;
  logic [7:0]    byte_i;
  logic          byte_vld_i;
  logic          byte_rdy_o;
  logic          wena_o;
  logic [AW-1:0] addra_o;
  logic [31:0]   dina_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  modport slave (
    input  start_i, byte_i, byte_vld_i,
    output byte_rdy_o, wena_o, addra_o, dina_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, byte_i, byte_vld_i,
    input  byte_rdy_o, wena_o, addra_o, dina_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/rv_instr_loader.sv
// Boot loader: takes a 16-bit little-endian word count followed by 4*N little-endian bytes
// and writes the assembled 32-bit words to instruction RAM addresses 0..N-1.
module rv_instr_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic              clk,
  input logic              rst_n,
  rv_instr_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    FIN
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state_reg;
  logic [15:0] len_reg;
  logic [15:0] word_cnt_reg;
  logic [1:0]  lane_reg;
  logic [7:0]  lane0_reg;
  logic [7:0]  lane1_reg;
  logic [7:0]  lane2_reg;

  logic        accept;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;

  assign accept    = bus.byte_vld_i & bus.byte_rdy_o;
  assign len_full  = {bus.byte_i, len_reg[7:0]};
  assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH_L);
  assign last_word = (word_cnt_reg == len_reg - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      word_cnt_reg   <= '0;
      lane_reg       <= '0;
      lane0_reg      <= '0;
      lane1_reg      <= '0;
      lane2_reg      <= '0;
      bus.byte_rdy_o <= 1'b0;
      bus.wena_o     <= 1'b0;
      bus.addra_o    <= '0;
      bus.dina_o     <= '0;
      bus.busy_o     <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.err_o      <= 1'b0;
    end else begin
      bus.wena_o <= 1'b0;
      bus.done_o <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            state_reg      <= LEN_LO;
            bus.err_o      <= 1'b0;
            bus.busy_o     <= 1'b1;
            bus.byte_rdy_o <= 1'b1;
          end
        end

        LEN_LO: begin
          if (accept) begin
            len_reg[7:0] <= bus.byte_i;
            state_reg    <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (accept) begin
            if (len_bad) begin
              bus.err_o      <= 1'b1;
              bus.busy_o     <= 1'b0;
              bus.byte_rdy_o <= 1'b0;
              state_reg      <= IDLE;
            end else begin
              len_reg[15:8] <= bus.byte_i;
              word_cnt_reg  <= '0;
              lane_reg      <= '0;
              state_reg     <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            if (lane_reg == 2'd3) begin
              bus.wena_o   <= 1'b1;
              bus.addra_o  <= word_cnt_reg[AW-1:0];
              bus.dina_o   <= {bus.byte_i, lane2_reg, lane1_reg, lane0_reg};
              word_cnt_reg <= word_cnt_reg + 16'd1;
              lane_reg     <= 2'd0;
              if (last_word) begin
                state_reg      <= FIN;
                bus.byte_rdy_o <= 1'b0;
              end
            end else begin
              case (lane_reg)
                2'd0:    lane0_reg <= bus.byte_i;
                2'd1:    lane1_reg <= bus.byte_i;
                default: lane2_reg <= bus.byte_i;
              endcase
              lane_reg <= lane_reg + 2'd1;
            end
          end
        end

        FIN: begin
          // start_i is deliberately not looked at here; a new load begins from IDLE only
          bus.done_o <= 1'b1;
          bus.busy_o <= 1'b0;
          state_reg  <= IDLE;
        end

        default: begin
          state_reg      <= IDLE;
          bus.busy_o     <= 1'b0;
          bus.byte_rdy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_instr_loader.sv
// Randomized scoreboard bench for rv_instr_loader: the driver pushes expected writes/done pulses
// derived from the byte list, and a negedge monitor pops and compares them.
module tb_rv_instr_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_instr_loader_if #(.AW(AW)) bus ();

  rv_instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every write and done pulse must match the oldest expectation
  always @(negedge clk) begin
    wr_t e;
    int  d;
    if (rst_n) begin
      if (bus.wena_o) begin
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write (cycle %0d)",
                   bus.addra_o, bus.dina_o, cyc);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", 32'(bus.addra_o), e.addr);
          chk("wr_data", bus.dina_o, e.data);
        end
      end
      if (bus.done_o) begin
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          d = exp_done.pop_front();
          chk("done_cycle", cyc, d);
          chk("busy_with_done", 32'(bus.busy_o), 0);
        end
      end
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_rdy"},   32'(bus.byte_rdy_o), 0);
    chk({tag, "_wena"},  32'(bus.wena_o), 0);
    chk({tag, "_addra"}, 32'(bus.addra_o), 0);
    chk({tag, "_dina"},  bus.dina_o, 0);
    chk({tag, "_busy"},  32'(bus.busy_o), 0);
    chk({tag, "_done"},  32'(bus.done_o), 0);
    chk({tag, "_err"},   32'(bus.err_o), 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("start_busy", 32'(bus.busy_o), 1);
    chk("start_rdy", 32'(bus.byte_rdy_o), 1);
    chk("start_err_clear", 32'(bus.err_o), 0);
  endtask

  // Presents one byte after `gap` idle cycles; acc = cycle count at the negedge before the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.byte_vld_i = 1'b0;
      chk("rdy_in_gap", 32'(bus.byte_rdy_o), 1);
    end
    @(negedge clk);
    bus.byte_vld_i = 1'b1;
    bus.byte_i     = b;
    for (int t = 0; !bus.byte_rdy_o; t++) begin
      if (t >= 100) begin
        checks++;
        failures++;
        $display("FAIL byte_timeout: got rdy=0 expected rdy=1 within 100 cycles");
        break;
      end
      @(negedge clk);
    end
    acc = cyc;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 300 && (exp_wr.size() != 0 || exp_done.size() != 0 || bus.busy_o); t++)
      @(negedge clk);
    chk("drain_pending", exp_wr.size() + exp_done.size(), 0);
    chk("drain_busy", 32'(bus.busy_o), 0);
  endtask

  // Reference model: N from the first two bytes, word k = bytes 2+4k..5+4k little-endian
  task automatic run_load(input logic [7:0] bytes[$], input int max_gap);
    int          n;
    int          acc;
    int          k;
    int          gap;
    bit          bad;
    logic [31:0] w;
    do_start();
    n   = int'(bytes[0]) + 256 * int'(bytes[1]);
    bad = (n == 0) || (n > DEPTH);
    for (int i = 0; i < bytes.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      send_byte(bytes[i], gap, acc);
      if (i == 1 && bad) break;
      if (i >= 2 && ((i - 2) % 4) == 3) begin
        k = (i - 2) / 4;
        w = {bytes[i], bytes[i-1], bytes[i-2], bytes[i-3]};
        exp_wr.push_back('{cyc: acc + 1, addr: k, data: w});
        if (k == n - 1) exp_done.push_back(acc + 2);
      end
    end
    @(negedge clk);
    bus.byte_vld_i = 1'b0;
    if (bad) begin
      chk("lenerr_err", 32'(bus.err_o), 1);
      chk("lenerr_busy", 32'(bus.busy_o), 0);
      chk("lenerr_rdy", 32'(bus.byte_rdy_o), 0);
    end else begin
      wait_idle();
      chk("load_err", 32'(bus.err_o), 0);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] big[$];
    int         acc;
    int         n;

    bus.start_i    = 1'b0;
    bus.byte_i     = 8'h00;
    bus.byte_vld_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Basic back-to-back load
    q = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(q, 0);

    // Zero length, then over length (start clears err inside do_start)
    q = {8'h00, 8'h00};
    run_load(q, 0);
    q = {8'h01, 8'h04};
    run_load(q, 0);

    // Stalled stream
    q = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(q, 5);

    // Reset mid-word: partial word must never be written
    do_start();
    q = {8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (q[i]) send_byte(q[i], 0, acc);
    @(negedge clk);
    rst_n          = 1'b0;
    bus.byte_vld_i = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    q = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(q, 0);

    // Random short loads with random gaps
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(6, 1));
      q = {8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      run_load(q, 3);
    end

    // Full fill with a start pulse while busy
    big = {8'h00, 8'h04};
    for (int k = 0; k < DEPTH; k++) begin
      big.push_back(8'(k));
      big.push_back(8'(k >> 8));
      big.push_back(8'h00);
      big.push_back(8'h00);
    end
    fork
      run_load(big, 0);
      begin
        repeat (600) @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
      end
    join

    repeat (3) @(negedge clk);
    chk("final_pending", exp_wr.size() + exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish within 2ms");
    $fatal(1, "timeout");
  end
endmodule
